// File: rtl/vend_pkg.sv
// Shared vending definitions: dispenser states, coin denominations, default widths.
package vend_pkg;

  localparam int VEND_AMT_W = 8;
  localparam int VEND_QTY_W = 4;

  localparam int DENOM_10 = 10;
  localparam int DENOM_5  = 5;
  localparam int DENOM_1  = 1;

  typedef enum logic [2:0] {
    IDLE,
    PROD_ON,
    PROD_GAP,
    COIN_ON,
    COIN_GAP,
    DONE
  } vend_state_e;

  // Greedy change: largest coin that does not exceed the remaining amount.
  function automatic int unsigned denom_for(input int unsigned amt);
    if (amt >= DENOM_10) return DENOM_10;
    else if (amt >= DENOM_5) return DENOM_5;
    else return DENOM_1;
  endfunction

endpackage

// File: rtl/vend_dispenser_pulse_timer.sv
// Down-counter pacing actuator ON and GAP phases; expired flags the last cycle of a phase.
module vend_dispenser_pulse_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Load the phase length minus one, then count down to zero and hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/vend_dispenser.sv
// Vend output stage: releases products, then pays change greedily in $10/$5/$1 coins
// as timed actuator pulses, and reports completion with a one-cycle done strobe.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W     = VEND_AMT_W,
  parameter int QTY_W     = VEND_QTY_W,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] price_q,
  input  logic [AMT_W-1:0] paid,
  input  logic [QTY_W-1:0] qty,
  output logic             prod_pulse,
  output logic             coin10_pulse,
  output logic             coin5_pulse,
  output logic             coin1_pulse,
  output logic             busy,
  output logic [AMT_W-1:0] change_left,
  output logic             err_underpay,
  output logic             done
);

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  vend_state_e      state, next_state;
  logic             accept;
  logic             underpay;
  logic [QTY_W-1:0] acc_prod;
  logic [AMT_W-1:0] acc_change;
  logic [QTY_W-1:0] prod_cnt;
  logic [QTY_W-1:0] prod_src;
  logic [AMT_W-1:0] chg_src;
  logic [AMT_W-1:0] denom_sel;
  logic [AMT_W-1:0] coin_val;
  logic             err_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_len;
  logic             tmr_expired;

  assign accept     = req_valid && req_ready;
  assign underpay   = (paid < price_q);
  assign acc_prod   = underpay ? '0 : qty;
  assign acc_change = underpay ? paid : (paid - price_q);

  // In IDLE the decision uses the request being accepted, afterwards the live counters.
  assign prod_src  = (state == IDLE) ? acc_prod : prod_cnt;
  assign chg_src   = (state == IDLE) ? acc_change : change_left;
  assign denom_sel = AMT_W'(denom_for(32'(chg_src)));

  vend_dispenser_pulse_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .len    (tmr_len),
    .expired(tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state selection and timer reload on every phase change.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_len    = CNT_W'(PULSE_CYC - 1);
    case (state)
      IDLE: begin
        if (accept) begin
          if (prod_src != '0)     next_state = PROD_ON;
          else if (chg_src != '0) next_state = COIN_ON;
          else                    next_state = DONE;
        end
      end
      PROD_ON:  if (tmr_expired) next_state = PROD_GAP;
      PROD_GAP: begin
        if (tmr_expired) begin
          if (prod_src != '0)     next_state = PROD_ON;
          else if (chg_src != '0) next_state = COIN_ON;
          else                    next_state = DONE;
        end
      end
      COIN_ON:  if (tmr_expired) next_state = COIN_GAP;
      COIN_GAP: begin
        if (tmr_expired) begin
          if (chg_src != '0) next_state = COIN_ON;
          else               next_state = DONE;
        end
      end
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (next_state != state) begin
      case (next_state)
        PROD_ON, COIN_ON: begin
          tmr_load = 1'b1;
          tmr_len  = CNT_W'(PULSE_CYC - 1);
        end
        PROD_GAP, COIN_GAP: begin
          tmr_load = 1'b1;
          tmr_len  = CNT_W'(GAP_CYC - 1);
        end
        default: tmr_load = 1'b0;
      endcase
    end
  end

  // Request capture, per-entry product/coin bookkeeping and the underpay strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_cnt    <= '0;
      change_left <= '0;
      coin_val    <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state == IDLE && accept) begin
        prod_cnt    <= acc_prod;
        change_left <= acc_change;
        err_q       <= underpay;
      end
      if (next_state == PROD_ON && state != PROD_ON) begin
        prod_cnt <= prod_src - QTY_W'(1);
      end
      if (next_state == COIN_ON && state != COIN_ON) begin
        change_left <= chg_src - denom_sel;
        coin_val    <= denom_sel;
      end
    end
  end

  assign prod_pulse   = (state == PROD_ON);
  assign coin10_pulse = (state == COIN_ON) && (coin_val == AMT_W'(DENOM_10));
  assign coin5_pulse  = (state == COIN_ON) && (coin_val == AMT_W'(DENOM_5));
  assign coin1_pulse  = (state == COIN_ON) && (coin_val == AMT_W'(DENOM_1));
  assign busy         = (state != IDLE);
  assign req_ready    = (state == IDLE);
  assign done         = (state == DONE);
  assign err_underpay = err_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: pulse sequences, change accounting, underpay,
// zero-work requests, async reset mid-pulse and request-while-busy behaviour.
module tb_vend_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] price_q;
  logic [7:0] paid;
  logic [3:0] qty;
  logic       prod_pulse, coin10_pulse, coin5_pulse, coin1_pulse;
  logic       busy;
  logic [7:0] change_left;
  logic       err_underpay;
  logic       done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vend_dispenser dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .price_q     (price_q),
    .paid        (paid),
    .qty         (qty),
    .prod_pulse  (prod_pulse),
    .coin10_pulse(coin10_pulse),
    .coin5_pulse (coin5_pulse),
    .coin1_pulse (coin1_pulse),
    .busy        (busy),
    .change_left (change_left),
    .err_underpay(err_underpay),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq: one char per pulse, P=product T=$10 F=$5 O=$1. chg[i]: change_left expected at
  // the first cycle of pulse slot i (slot n is the done cycle). With hold, req_valid stays
  // high and the data lines are scrambled, then set to the next request before done.
  task automatic run_req(input logic [7:0] pr, input logic [7:0] pd, input logic [3:0] q,
                         input string seq, input logic exp_err, input int chg[8],
                         input bit hold, input logic [7:0] npr, input logic [7:0] npd,
                         input logic [3:0] nq);
    int n;
    int total;
    logic [3:0] ev;
    req_valid = 1'b1;
    price_q   = pr;
    paid      = pd;
    qty       = q;
    tick();
    if (!hold) req_valid = 1'b0;
    n     = seq.len();
    total = n * 8 + 1;
    for (int c = 1; c <= total; c++) begin
      ev = 4'b0000;
      if (c <= n * 8 && ((c - 1) % 8) < 4) begin
        case (seq[(c - 1) / 8])
          "P":     ev = 4'b1000;
          "T":     ev = 4'b0100;
          "F":     ev = 4'b0010;
          default: ev = 4'b0001;
        endcase
      end
      chk($sformatf("pulses[%s c=%0d]", seq, c),
          32'({prod_pulse, coin10_pulse, coin5_pulse, coin1_pulse}), 32'(ev));
      chk($sformatf("done[%s c=%0d]", seq, c), 32'(done), 32'(c == total));
      chk($sformatf("busy[%s c=%0d]", seq, c), 32'(busy), 32'd1);
      if (((c - 1) % 8) == 0 && ((c - 1) / 8) < 8)
        chk($sformatf("change_left[%s c=%0d]", seq, c), 32'(change_left),
            32'(chg[(c - 1) / 8]));
      if (c == 1) chk($sformatf("err_underpay[%s c=1]", seq), 32'(err_underpay), 32'(exp_err));
      if (c == 2) chk($sformatf("err_underpay[%s c=2]", seq), 32'(err_underpay), 32'd0);
      if (hold && c == 3) begin
        price_q = 8'hFF;
        paid    = 8'd1;
        qty     = 4'd15;
      end
      if (hold && c == total) begin
        price_q = npr;
        paid    = npd;
        qty     = nq;
      end
      tick();
    end
    chk($sformatf("req_ready_after[%s]", seq), 32'(req_ready), 32'd1);
    chk($sformatf("busy_after[%s]", seq), 32'(busy), 32'd0);
    chk($sformatf("done_after[%s]", seq), 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    price_q   = '0;
    paid      = '0;
    qty       = '0;
    #12;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pulses", 32'({prod_pulse, coin10_pulse, coin5_pulse, coin1_pulse}), 32'd0);
    chk("reset_change", 32'(change_left), 32'd0);
    chk("reset_done_err", 32'({done, err_underpay}), 32'd0);
    reset = 1'b0;
    tick();

    // Exact payment, two products, no change.
    run_req(8'd20, 8'd20, 4'd2, "PP", 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 8'd0, 8'd0, 4'd0);
    // One product, change 17 -> 10,5,1,1.
    run_req(8'd6, 8'd23, 4'd1, "PTFOO", 1'b0, '{17, 7, 2, 1, 0, 0, 0, 0}, 1'b0, 8'd0, 8'd0, 4'd0);
    // Underpay: refund 7 -> 5,1,1, no product.
    run_req(8'd10, 8'd7, 4'd3, "FOO", 1'b1, '{2, 1, 0, 0, 0, 0, 0, 0}, 1'b0, 8'd0, 8'd0, 4'd0);
    // Zero work.
    run_req(8'd0, 8'd0, 4'd0, "", 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 8'd0, 8'd0, 4'd0);
    // Coins only: 12 -> 10,1,1.
    run_req(8'd0, 8'd12, 4'd0, "TOO", 1'b0, '{2, 1, 0, 0, 0, 0, 0, 0}, 1'b0, 8'd0, 8'd0, 4'd0);

    // Async reset in the middle of a $10 pulse.
    req_valid = 1'b1;
    price_q   = 8'd0;
    paid      = 8'd12;
    qty       = 4'd0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_coin10", 32'(coin10_pulse), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_pulses", 32'({prod_pulse, coin10_pulse, coin5_pulse, coin1_pulse}), 32'd0);
    chk("async_reset_ready", 32'(req_ready), 32'd1);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_change", 32'(change_left), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_req(8'd20, 8'd20, 4'd2, "PP", 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 8'd0, 8'd0, 4'd0);

    // req_valid held through a busy request: second request taken only after done.
    run_req(8'd20, 8'd20, 4'd1, "P", 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 8'd0, 8'd12, 4'd0);
    run_req(8'd0, 8'd12, 4'd0, "TOO", 1'b0, '{2, 1, 0, 0, 0, 0, 0, 0}, 1'b0, 8'd0, 8'd0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
